// File: rtl/switches_to_leds_and_gate.sv
// Two-switch AND demo: each raw switch is synchronized and debounced on its
// own channel, and the LED shows the registered AND of the two clean states.
module switches_to_leds_and_gate #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch_0,
  input  logic i_Switch_1,
  output logic o_LED_0
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0] sw_raw;
  logic [1:0] state_w;
  logic       led_q;
  logic       led_d;

  assign sw_raw = {i_Switch_1, i_Switch_0};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   state_q;
    logic                   state_d;

    // Shift the raw switch through the synchronizer chain.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw[ch]};
      end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Accept a new level only after it has differed from the debounced state
    // for DEBOUNCE_LIMIT consecutive cycles; any return to the old level
    // discards the partial count.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (sync_out == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = sync_out;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // Debouncer state and counter registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        state_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign state_w[ch] = state_q;
  end

  assign led_d = state_w[0] & state_w[1];

  // Register the AND so the LED pad is driven straight from a flop.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign o_LED_0 = led_q;

endmodule

// File: tb/tb_switches_to_leds_and_gate.sv
// Bench for switches_to_leds_and_gate with a short debounce window. The
// reference model treats each channel as a delay line followed by a
// sliding window: a level is accepted once the last DL delayed samples all
// disagree with the current debounced state.
module tb_switches_to_leds_and_gate;

  localparam int DL  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + DL + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sw0 = 1'b0;
  logic sw1 = 1'b0;
  logic led;

  int checks   = 0;
  int failures = 0;

  bit pipe0[$];
  bit pipe1[$];
  bit win0[$];
  bit win1[$];
  bit st0;
  bit st1;
  bit led_m;

  switches_to_leds_and_gate #(
    .DEBOUNCE_LIMIT(DL),
    .SYNC_STAGES   (SS)
  ) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_Switch_0(sw0),
    .i_Switch_1(sw1),
    .o_LED_0   (led)
  );

  always #5 clk = ~clk;

  function automatic bit settled(input bit w[$], input bit st);
    if (w.size() < DL) return 1'b0;
    foreach (w[i]) if (w[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    pipe0 = {};
    pipe1 = {};
    win0  = {};
    win1  = {};
    for (int i = 0; i < SS; i++) begin
      pipe0.push_back(1'b0);
      pipe1.push_back(1'b0);
    end
    st0   = 1'b0;
    st1   = 1'b0;
    led_m = 1'b0;
  endtask

  // One rising edge: advance the model with the levels the DUT samples, then
  // settle 1 ns past the edge.
  task automatic tick();
    bit d0, d1;
    @(posedge clk);
    led_m = st0 & st1;
    d0 = pipe0.pop_front();
    d1 = pipe1.pop_front();
    pipe0.push_back(sw0);
    pipe1.push_back(sw1);
    win0.push_back(d0);
    win1.push_back(d1);
    if (win0.size() > DL) void'(win0.pop_front());
    if (win1.size() > DL) void'(win1.pop_front());
    if (settled(win0, st0)) st0 = d0;
    if (settled(win1, st1)) st1 = d1;
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
  endtask

  task automatic reset_release();
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bit exp;
    #2;
    reset_pulse();
    checks++;
    if (led !== 1'b0) begin
      failures++;
      $display("FAIL reset_state led=%b exp=0", led);
    end
    reset_release();
    sw0 = 1'b1;
    sw1 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (led !== 1'b1) begin
      failures++;
      $display("FAIL reset_prelit led=%b exp=1", led);
    end
    reset_pulse();
    checks++;
    if (led !== 1'b0) begin
      failures++;
      $display("FAIL reset_async led=%b exp=0", led);
    end
    reset_release();
    for (int i = 1; i <= LAT; i++) begin
      tick();
      exp = (i >= LAT);
      checks++;
      if (led !== exp) begin
        failures++;
        $display("FAIL reset_latency edge=%0d led=%b exp=%b", i, led, exp);
      end
    end
  endtask

  task automatic test_truth_table();
    bit [1:0] pats [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    bit prev;
    bit exp;
    prev = 1'b1;
    for (int p = 0; p < 4; p++) begin
      sw1 = pats[p][1];
      sw0 = pats[p][0];
      exp = pats[p][1] & pats[p][0];
      for (int i = 1; i <= 20; i++) begin
        tick();
        checks++;
        if (led !== led_m) begin
          failures++;
          $display("FAIL tt_model pat=%b edge=%0d led=%b exp=%b", pats[p], i, led, led_m);
        end
        if (i == LAT - 1) begin
          checks++;
          if (led !== prev) begin
            failures++;
            $display("FAIL tt_hold pat=%b led=%b exp=%b", pats[p], led, prev);
          end
        end
        if (i == LAT) begin
          checks++;
          if (led !== exp) begin
            failures++;
            $display("FAIL tt_settle pat=%b led=%b exp=%b", pats[p], led, exp);
          end
        end
      end
      prev = exp;
    end
  endtask

  task automatic test_bounce();
    int rises;
    int rise_at;
    bit last;
    sw0 = 1'b1;
    sw1 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    for (int i = 0; i < 30; i++) begin
      sw1 = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      checks++;
      if (led !== 1'b0 || led !== led_m) begin
        failures++;
        $display("FAIL bounce_low cyc=%0d led=%b exp=0 model=%b", i, led, led_m);
      end
    end
    sw1 = 1'b1;
    rises = 0;
    rise_at = 0;
    last = led;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (led === 1'b1 && last === 1'b0) begin
        rises++;
        if (rise_at == 0) rise_at = i;
      end
      last = led;
    end
    checks++;
    if (rises != 1) begin
      failures++;
      $display("FAIL bounce_rises got=%0d exp=1", rises);
    end
    checks++;
    if (rise_at != LAT) begin
      failures++;
      $display("FAIL bounce_latency got=%0d exp=%0d", rise_at, LAT);
    end
  endtask

  task automatic test_release();
    bit exp;
    sw0 = 1'b1;
    sw1 = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (led !== 1'b1) begin
      failures++;
      $display("FAIL release_pre led=%b exp=1", led);
    end
    sw0 = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      exp = (i < LAT);
      checks++;
      if (led !== exp) begin
        failures++;
        $display("FAIL release_latency edge=%0d led=%b exp=%b", i, led, exp);
      end
    end
    sw0 = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    sw0 = 1'b0;
    tick();
    tick();
    sw0 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (led !== 1'b1 || led !== led_m) begin
        failures++;
        $display("FAIL dropout_hold edge=%0d led=%b exp=1 model=%b", i, led, led_m);
      end
    end
  endtask

  task automatic test_simultaneous();
    int rises;
    int rise_at;
    bit last;
    sw0 = 1'b0;
    sw1 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    sw0 = 1'b1;
    sw1 = 1'b1;
    rises = 0;
    rise_at = 0;
    last = led;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (led === 1'b1 && last === 1'b0) begin
        rises++;
        if (rise_at == 0) rise_at = i;
      end
      last = led;
    end
    checks++;
    if (rises != 1 || rise_at != LAT) begin
      failures++;
      $display("FAIL simul_rise rises=%0d at=%0d exp rises=1 at=%0d", rises, rise_at, LAT);
    end
  endtask

  task automatic test_mid_reset();
    bit exp;
    sw0 = 1'b0;
    sw1 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    sw0 = 1'b1;
    sw1 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset_pulse();
    checks++;
    if (led !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async led=%b exp=0", led);
    end
    reset_release();
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      exp = (i >= LAT);
      checks++;
      if (led !== exp) begin
        failures++;
        $display("FAIL midreset_latency edge=%0d led=%b exp=%b", i, led, exp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) sw0 = ~sw0;
      if ($urandom_range(5) == 0) sw1 = ~sw1;
      if ($urandom_range(499) == 0) begin
        reset_pulse();
        checks++;
        if (led !== 1'b0) begin
          failures++;
          $display("FAIL random_reset cyc=%0d led=%b exp=0", i, led);
        end
        reset_release();
      end
      tick();
      checks++;
      if (led !== led_m) begin
        failures++;
        $display("FAIL random_model cyc=%0d sw=%b%b led=%b exp=%b", i, sw1, sw0, led, led_m);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_truth_table();
    test_bounce();
    test_release();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switches_to_leds_and_gate.md
# switches_to_leds_and_gate

Two-input logic demo block for the board's switch/LED bank. It synchronizes and debounces two mechanical switch inputs, then drives one LED with the logical AND of the two clean switch states. It sits directly between the top-level switch pads and LED pads, with no bus interface. The output is registered, so the LED never reflects bounce or metastable glitches.

## Interface
Parameters:
- DEBOUNCE_LIMIT, default 250000: consecutive stable clock cycles required before a switch change is accepted (10 ms at 25 MHz); legal range ≥ 1.
- SYNC_STAGES, default 2: flip-flop depth of each input synchronizer; legal range ≥ 2.

Ports:
- i_Clk, input, 1: system clock; all state is on its rising edge.
- i_Reset, input, 1: asynchronous, active-high reset.
- i_Switch_0, input, 1: raw switch 0, asynchronous to i_Clk, 1 = pressed/on.
- i_Switch_1, input, 1: raw switch 1, asynchronous to i_Clk, 1 = pressed/on.
- o_LED_0, output, 1: 1 = LED lit; registered AND of the debounced switch states.

## Operation
Each switch has an identical, independent channel:
- **Synchronizer:** a SYNC_STAGES-deep flop chain, reset to 0. Only the last stage is used downstream.
- **Debouncer:**
  - State: debounced state r_State (reset 0) and counter r_Count (width $clog2(DEBOUNCE_LIMIT+1), reset 0).
  - Each cycle, if the synchronized value equals r_State, then r_Count <= 0.
  - Otherwise, if r_Count == DEBOUNCE_LIMIT-1, then r_State <= synchronized value and r_Count <= 0.
  - Otherwise, r_Count <= r_Count + 1.
  - A glitch shorter than DEBOUNCE_LIMIT cycles restarts the count and is discarded.
  - The counter never wraps; it saturates by construction at DEBOUNCE_LIMIT-1.

Output logic:
- o_LED_0 <= r_State_0 & r_State_1 each cycle, from a flop.
- Truth table of the debounced states: 00→0, 01→0, 10→0, 11→1.

Reset behavior:
- i_Reset asserted at any time forces every synchronizer stage, r_State, r_Count and o_LED_0 to 0 immediately, without waiting for a clock edge.
- After i_Reset deasserts, the switches are re-evaluated from scratch. A switch held at 1 through reset must still wait the full latency before the LED can light.

Simultaneous and independent events:
- Both switches may change on the same cycle. Each channel debounces independently.
- If both settle at 1 on the same cycle, o_LED_0 rises exactly once.
- No intermediate states are possible.

## Timing
- Latency is defined as the number of rising edges from the first edge that samples a new stable switch level until o_LED_0 reflects it. It is SYNC_STAGES + DEBOUNCE_LIMIT + 1 edges, which equals DEBOUNCE_LIMIT + 3 with default SYNC_STAGES.
- Release latency (1→0) equals press latency. The block is symmetric.
- If the two switches settle on different cycles, o_LED_0 follows whichever channel accepts its change last.
- o_LED_0 changes only on rising edges of i_Clk, or asynchronously to 0 on i_Reset assertion.
- o_LED_0 is glitch-free and is driven directly from a flop.
- No handshake and no ready/valid signals.

## Test plan
All scenarios use DEBOUNCE_LIMIT=4, SYNC_STAGES=2 and a 10 ns clock.
- **Reset:** assert i_Reset with both switches at 1 → o_LED_0=0 immediately. Deassert → o_LED_0 stays 0 for 6 edges, then becomes 1 on the 7th edge.
- **Truth table:** drive stable (0,0), (0,1), (1,0), (1,1), holding each for 20 cycles → o_LED_0 settles to 0, 0, 0, 1 respectively, each 7 edges after the change.
- **Bounce rejection:** with i_Switch_0=1, toggle i_Switch_1 0→1→0 with 3-cycle pulses for 30 cycles, then hold 1 → o_LED_0 stays 0 throughout the bouncing and rises exactly once, 7 edges after the final stable 1.
- **Release:** from (1,1) with o_LED_0=1, drop i_Switch_0 to 0 → o_LED_0 falls 7 edges later. A 2-cycle dropout of i_Switch_0 instead leaves o_LED_0=1.
- **Simultaneous change:** (0,0)→(1,1) on the same cycle → exactly one rising transition of o_LED_0, 7 edges later.
- **Mid-operation reset:** assert i_Reset with r_Count mid-count → o_LED_0 and all counters are 0. After release, the full latency applies again.
